// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      WRITE,
      DONE
   } state_t;

   // Default capacity: 256 words of 32 bits (1 KB)
   localparam int MAX_WORDS_DEF = 256;
   // Default byte-address width of the instruction-memory write port
   localparam int ADDR_W_DEF    = 10;
   // Image header carries a 16-bit big-endian word count
   localparam int HDR_W         = 16;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words (first byte -> bits 31:24).
// Latency: word_vld/word_dat are combinational with the 4th accepted byte.
// Backpressure: none of its own; byte_vld must already be the handshake qualifier.
module word_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_dat,
   output logic        word_vld,
   output logic [31:0] word_dat
);

   logic [1:0]  byte_cnt;
   logic [31:0] shift_q;

   // Shift accepted bytes in and count position within the word; clr restarts alignment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt <= 2'd0;
         shift_q  <= 32'd0;
      end else if (clr) begin
         byte_cnt <= 2'd0;
         shift_q  <= 32'd0;
      end else if (byte_vld) begin
         byte_cnt <= byte_cnt + 2'd1;
         shift_q  <= {shift_q[23:0], byte_dat};
      end
   end

   // The completed word includes the byte being accepted right now
   assign word_vld = byte_vld && (byte_cnt == 2'd3);
   assign word_dat = {shift_q[23:0], byte_dat};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding the CPU in reset.
// Latency: one WRITE cycle after every 4th accepted byte; DONE the cycle after the last write.
// Backpressure: in_ready is low outside HDR0/HDR1/DATA, so the sender stalls during WRITE/IDLE/DONE.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MAX_WORDS = MAX_WORDS_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [8:0]        loaded_words
);

   state_t           state;
   logic [HDR_W-1:0] len;

   logic             accept;
   logic             start_ok;
   logic [HDR_W-1:0] hdr_len;
   logic             hdr_bad;
   logic [8:0]       words_inc;
   logic             word_vld;
   logic [31:0]      word_dat;

   assign accept    = in_valid && in_ready;
   // start only counts while idle or finished; elsewhere it is ignored
   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   // Length as it will be once the low header byte is taken
   assign hdr_len   = {len[15:8], in_data};
   assign hdr_bad   = (hdr_len == '0) || (int'(hdr_len) > MAX_WORDS);
   assign words_inc = loaded_words + 9'd1;

   word_assembler u_word_assembler (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_ok),
      .byte_vld (accept && (state == DATA)),
      .byte_dat (in_data),
      .word_vld (word_vld),
      .word_dat (word_dat)
   );

   // Loader FSM with all outputs registered alongside the state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         in_ready     <= 1'b0;
         im_we        <= 1'b0;
         im_addr      <= '0;
         im_wdata     <= 32'd0;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         loaded_words <= 9'd0;
         len          <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  state        <= HDR0;
                  in_ready     <= 1'b1;
                  loaded_words <= 9'd0;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  cpu_hold     <= 1'b1;
               end
            end
            HDR0: begin
               if (accept) begin
                  len[15:8] <= in_data;
                  state     <= HDR1;
               end
            end
            HDR1: begin
               if (accept) begin
                  len[7:0] <= in_data;
                  if (hdr_bad) begin
                     // Rejected image: finish without writing and keep the CPU held
                     state    <= DONE;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                     err      <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (word_vld) begin
                  state    <= WRITE;
                  in_ready <= 1'b0;
                  im_we    <= 1'b1;
                  im_addr  <= ADDR_W'({loaded_words, 2'b00});
                  im_wdata <= word_dat;
               end
            end
            WRITE: begin
               im_we        <= 1'b0;
               loaded_words <= words_inc;
               if ({7'd0, words_inc} == len) begin
                  // Image complete: release the CPU as DONE is entered
                  state    <= DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end else begin
                  state    <= DATA;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               im_we    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: table of image loads plus reset/start corner sequences.
// Latency: n/a.
// Backpressure: sender honours in_ready and may insert idle cycles.
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        im_we;
   logic [9:0]  im_addr;
   logic [31:0] im_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [8:0]  loaded_words;

   int n_chk  = 0;
   int n_fail = 0;
   int ovl    = 0;

   logic [9:0]  wq_addr[$];
   logic [31:0] wq_dat[$];

   typedef struct {
      string       name;
      logic [15:0] len;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          toggle;
      bit          exp_err;
      int          exp_words;
   } vec_t;

   vec_t vecs[6];

   imem_loader #(.MAX_WORDS(256), .ADDR_W(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .loaded_words (loaded_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every memory write; flag any cycle where a byte could be taken during a write
   always @(negedge clk) begin
      if (rst && im_we) begin
         wq_addr.push_back(im_addr);
         wq_dat.push_back(im_wdata);
         if (in_ready) ovl++;
      end
   end

   function automatic logic [31:0] word_of(input logic [31:0] w0, input logic [31:0] w1, input int k);
      if (k == 0) return w0;
      if (k == 1) return w1;
      return {8'(k), 8'(k * 3), 8'hC3, 8'(255 - k)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte has been taken
   task automatic send_byte(input logic [7:0] b, input bit toggle);
      int budget = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_byte timeout: in_ready %0b expected 1", in_ready);
      end
      @(negedge clk);
      if (toggle) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit toggle);
      for (int b = 0; b < 4; b++) send_byte(w[31 - 8 * b -: 8], toggle);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int c = 0;
      while (!done && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk({name, " done_seen"}, {31'd0, done}, 32'd1);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, " in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({name, " im_we"}, {31'd0, im_we}, 32'd0);
      chk({name, " im_addr"}, {22'd0, im_addr}, 32'd0);
      chk({name, " im_wdata"}, im_wdata, 32'd0);
      chk({name, " cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
      chk({name, " done"}, {31'd0, done}, 32'd0);
      chk({name, " err"}, {31'd0, err}, 32'd0);
      chk({name, " loaded_words"}, {23'd0, loaded_words}, 32'd0);
   endtask

   initial begin
      int ovl0;
      int seen_rdy;

      vecs[0] = '{"len2_cont",   16'd2,   32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, 2};
      vecs[1] = '{"len2_toggle", 16'd2,   32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, 2};
      vecs[2] = '{"len257",      16'd257, 32'h0,        32'h0,        1'b0, 1'b1, 0};
      vecs[3] = '{"len0",        16'd0,   32'h0,        32'h0,        1'b0, 1'b1, 0};
      vecs[4] = '{"len256",      16'd256, 32'hA0B0C0D0, 32'h01020304, 1'b0, 1'b0, 256};
      vecs[5] = '{"len1_toggle", 16'd1,   32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 1};

      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b1;
      @(negedge clk);

      // Table-driven image loads
      for (int i = 0; i < 6; i++) begin
         wq_addr.delete();
         wq_dat.delete();
         ovl0 = ovl;
         pulse_start();
         send_byte(vecs[i].len[15:8], vecs[i].toggle);
         send_byte(vecs[i].len[7:0], vecs[i].toggle);
         if (!vecs[i].exp_err) begin
            for (int k = 0; k < int'(vecs[i].len); k++)
               send_word(word_of(vecs[i].w0, vecs[i].w1, k), vecs[i].toggle);
         end
         in_valid = 1'b0;
         wait_done(vecs[i].name);
         repeat (2) @(negedge clk);
         chk({vecs[i].name, " writes"}, 32'(wq_addr.size()), 32'(vecs[i].exp_words));
         for (int k = 0; k < wq_addr.size() && k < vecs[i].exp_words; k++) begin
            chk({vecs[i].name, " addr"}, {22'd0, wq_addr[k]}, 32'(4 * k));
            chk({vecs[i].name, " data"}, wq_dat[k], word_of(vecs[i].w0, vecs[i].w1, k));
         end
         chk({vecs[i].name, " done"}, {31'd0, done}, 32'd1);
         chk({vecs[i].name, " err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
         chk({vecs[i].name, " cpu_hold"}, {31'd0, cpu_hold}, {31'd0, vecs[i].exp_err});
         chk({vecs[i].name, " loaded_words"}, {23'd0, loaded_words}, 32'(vecs[i].exp_words));
         chk({vecs[i].name, " ready_during_write"}, 32'(ovl - ovl0), 32'd0);
      end

      // Reset in the middle of a len=3 load, after 5 bytes
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1 chk_reset_vals("midload_rst");
      @(negedge clk);
      rst = 1'b1;
      wq_addr.delete();
      wq_dat.delete();
      seen_rdy = 0;
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (6) begin
         @(negedge clk);
         if (in_ready) seen_rdy++;
      end
      in_valid = 1'b0;
      chk("nostart in_ready", 32'(seen_rdy), 32'd0);
      chk("nostart writes", 32'(wq_addr.size()), 32'd0);
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_word(32'h89ABCDEF, 1'b0);
      in_valid = 1'b0;
      wait_done("reload");
      @(negedge clk);
      chk("reload writes", 32'(wq_addr.size()), 32'd1);
      if (wq_addr.size() > 0) begin
         chk("reload addr", {22'd0, wq_addr[0]}, 32'd0);
         chk("reload data", wq_dat[0], 32'h89ABCDEF);
      end
      chk("reload loaded_words", {23'd0, loaded_words}, 32'd1);

      // start asserted while in DATA must be ignored
      wq_addr.delete();
      wq_dat.delete();
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'hDE, 1'b0);
      send_byte(8'hAD, 1'b0);
      start = 1'b1;
      send_byte(8'hBE, 1'b0);
      start = 1'b0;
      send_byte(8'hEF, 1'b0);
      send_word(32'h12345678, 1'b0);
      in_valid = 1'b0;
      wait_done("start_in_data");
      @(negedge clk);
      chk("start_in_data writes", 32'(wq_addr.size()), 32'd2);
      if (wq_addr.size() > 1) begin
         chk("start_in_data data0", wq_dat[0], 32'hDEADBEEF);
         chk("start_in_data addr1", {22'd0, wq_addr[1]}, 32'd4);
         chk("start_in_data data1", wq_dat[1], 32'h12345678);
      end
      chk("start_in_data loaded_words", {23'd0, loaded_words}, 32'd2);
      chk("start_in_data cpu_hold", {31'd0, cpu_hold}, 32'd0);

      // start together with in_valid in DONE: no byte taken that cycle
      wq_addr.delete();
      wq_dat.delete();
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h01;
      @(negedge clk);
      start = 1'b0;
      chk("restart in_ready", {31'd0, in_ready}, 32'd1);
      chk("restart cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("restart done", {31'd0, done}, 32'd0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_word(32'h0F1E2D3C, 1'b0);
      in_valid = 1'b0;
      wait_done("restart");
      @(negedge clk);
      chk("restart writes", 32'(wq_addr.size()), 32'd1);
      if (wq_addr.size() > 0) begin
         chk("restart addr", {22'd0, wq_addr[0]}, 32'd0);
         chk("restart data", wq_dat[0], 32'h0F1E2D3C);
      end
      chk("restart loaded_words", {23'd0, loaded_words}, 32'd1);
      chk("restart err", {31'd0, err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
